scr1_imem_router_mp: RTL and testbench

//  N-port instruction-memory router between the SCR1 core IMEM interface and NPORTS

---
 rtl/scr1_imem_router_mp.sv | 178 +++++++++++++++++
 tb/tb_scr1_imem_router_mp.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/scr1_imem_router_mp.sv
// scr1_imem_router_mp: N-port instruction-memory router for the SCR1 IMEM interface.
// Each fetch address is decoded against per-port mask/pattern windows (lowest index wins).
// Up to OUTST_MAX fetches may be in flight at once. All in-flight fetches go to the same port,
// so responses come back in order. A fetch to a different port waits until the last
// outstanding response returns; it may issue in that same cycle.
// Responses are passed combinationally from the port that holds the in-flight fetches.
// Optional macro SCR1_IMEM_ROUTER_DECERR_EN: an address that matches no window is not forwarded.
// The router acks it locally and answers with RDY_ER on the next cycle. Without the macro,
// unmatched addresses go to port NPORTS-1.
// SCR1_TRGT_SIMULATION enables the embedded assertions.

`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif
`ifndef SCR1_IMEM_DWIDTH
`define SCR1_IMEM_DWIDTH 32
`endif

module scr1_imem_router_mp #(
    parameter int NPORTS    = 2,
    parameter int OUTST_MAX = 2,
    parameter logic [NPORTS*`SCR1_IMEM_AWIDTH-1:0] ADDR_MASK =
        {NPORTS{{(`SCR1_IMEM_AWIDTH-16){1'b1}}, 16'h0000}},
    parameter logic [NPORTS*`SCR1_IMEM_AWIDTH-1:0] ADDR_PATT = '0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                imem_req,
    input  logic                                imem_cmd,
    input  logic [`SCR1_IMEM_AWIDTH-1:0]        imem_addr,
    output logic                                imem_req_ack,
    output logic [`SCR1_IMEM_DWIDTH-1:0]        imem_rdata,
    output logic [1:0]                          imem_resp,
    output logic [NPORTS-1:0]                   port_req,
    output logic [NPORTS-1:0]                   port_cmd,
    output logic [NPORTS*`SCR1_IMEM_AWIDTH-1:0] port_addr,
    input  logic [NPORTS-1:0]                   port_req_ack,
    input  logic [NPORTS*`SCR1_IMEM_DWIDTH-1:0] port_rdata,
    input  logic [NPORTS*2-1:0]                 port_resp
);

    localparam int AW = `SCR1_IMEM_AWIDTH;
    localparam int DW = `SCR1_IMEM_DWIDTH;
    // cur must be able to hold the pseudo-index NPORTS (local decode error)
    localparam int CW = $clog2(NPORTS + 1);
    localparam int NW = $clog2(OUTST_MAX + 1);

    localparam logic       CMD_RD      = 1'b0;
    localparam logic [1:0] RESP_NOTRDY = 2'b00;
    localparam logic [1:0] RESP_RDY_OK = 2'b01;
    localparam logic [1:0] RESP_RDY_ER = 2'b10;

    logic [NW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] cur_reg, cur_next;
    logic [CW-1:0] sel;
    logic          sel_ack;
    logic          sel_is_port;
    logic [NPORTS-1:0] hit;
    logic [1:0]    resp_a  [NPORTS];
    logic [DW-1:0] rdata_a [NPORTS];
    logic [1:0]    cur_resp;
    logic [DW-1:0] cur_rdata;
    logic          pop;
    logic          push;
    logic          can_issue;
    logic [NW-1:0] cnt_left;

    // Per-port window match and unpacking of the response buses
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port_in
            assign hit[gi]     = ((imem_addr & ADDR_MASK[gi*AW +: AW]) == ADDR_PATT[gi*AW +: AW]);
            assign resp_a[gi]  = port_resp[gi*2 +: 2];
            assign rdata_a[gi] = port_rdata[gi*DW +: DW];
        end
    endgenerate

    // Address decode: the lowest matching window wins. With no match, use the default port
    // or the local-error pseudo-port.
    always_comb begin
`ifdef SCR1_IMEM_ROUTER_DECERR_EN
        sel = CW'(NPORTS);
`else
        sel = CW'(NPORTS - 1);
`endif
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel = CW'(i);
            end
        end
    end

    // Response mux from the port owning the in-flight fetches.
    // The pseudo-port answers with an error.
    always_comb begin
        cur_resp  = RESP_NOTRDY;
        cur_rdata = '0;
        if (cnt_reg != '0) begin
`ifdef SCR1_IMEM_ROUTER_DECERR_EN
            if (cur_reg == CW'(NPORTS)) begin
                cur_resp = RESP_RDY_ER;
            end
`endif
            for (int i = 0; i < NPORTS; i++) begin
                if (cur_reg == CW'(i)) begin
                    cur_resp  = resp_a[i];
                    cur_rdata = rdata_a[i];
                end
            end
        end
    end

    // Issue decision: respect the in-flight limit, and keep all in-flight fetches on one port
    always_comb begin
        pop      = (cnt_reg != '0) && ((cur_resp == RESP_RDY_OK) || (cur_resp == RESP_RDY_ER));
        cnt_left = cnt_reg - NW'(pop);
`ifdef SCR1_IMEM_ROUTER_DECERR_EN
        sel_is_port = (sel != CW'(NPORTS));
`else
        sel_is_port = 1'b1;
`endif
        can_issue = rst_n & imem_req
                  & (cnt_left < NW'(OUTST_MAX))
                  & ((cnt_left == '0) | (sel == cur_reg))
                  & (sel_is_port | (cnt_left == '0));
        // A locally answered decode error needs no slave handshake
        sel_ack = !sel_is_port;
        for (int i = 0; i < NPORTS; i++) begin
            if (sel == CW'(i)) begin
                sel_ack = port_req_ack[i];
            end
        end
        push = can_issue & sel_ack;
    end

    assign imem_req_ack = push;
    assign imem_resp    = cur_resp;
    assign imem_rdata   = cur_rdata;

    // Per-port request outputs. Unselected ports see a clean read of address 0.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port_out
            assign port_req[gi]            = can_issue & (sel == CW'(gi));
            assign port_cmd[gi]            = (sel == CW'(gi)) ? imem_cmd : CMD_RD;
            assign port_addr[gi*AW +: AW]  = (sel == CW'(gi)) ? imem_addr : '0;
        end
    endgenerate

    // Next in-flight count and owning port
    always_comb begin
        cnt_next = cnt_reg + NW'(push) - NW'(pop);
        cur_next = push ? sel : cur_reg;
    end

    // State registers. An asynchronous reset drops all in-flight bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            cur_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            cur_reg <= cur_next;
        end
    end

`ifdef SCR1_TRGT_SIMULATION
    a_no_x_req: assert property (@(posedge clk) disable iff (!rst_n)
        imem_req |-> !$isunknown({imem_cmd, imem_addr}));
    a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_reg <= NW'(OUTST_MAX));
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_sva
            a_no_stray: assert property (@(posedge clk) disable iff (!rst_n)
                (port_resp[gi*2 +: 2] != RESP_NOTRDY) |-> ((cnt_reg != '0) && (cur_reg == CW'(gi))));
        end
    endgenerate
`endif

endmodule

// File: tb/tb_scr1_imem_router_mp.sv
// Testbench for scr1_imem_router_mp: 3 ports (windows 0x0000_xxxx, 0x0001_xxxx, 0x0002_xxxx),
// OUTST_MAX=2. The bench models the slave ports as in-order fetch queues. The reference keeps
// a queue of in-flight fetch targets.
`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif
`ifndef SCR1_IMEM_DWIDTH
`define SCR1_IMEM_DWIDTH 32
`endif

module tb_scr1_imem_router_mp;
    localparam int NP = 3;
    localparam int OM = 2;
    localparam logic [1:0] NOTRDY = 2'b00;
    localparam logic [1:0] RDY_OK = 2'b01;
    localparam logic [1:0] RDY_ER = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              imem_req = 1'b0;
    logic              imem_cmd = 1'b0;
    logic [31:0]       imem_addr = '0;
    logic              imem_req_ack;
    logic [31:0]       imem_rdata;
    logic [1:0]        imem_resp;
    logic [NP-1:0]     port_req;
    logic [NP-1:0]     port_cmd;
    logic [NP*32-1:0]  port_addr;
    logic [NP-1:0]     port_req_ack = '0;
    logic [NP*32-1:0]  port_rdata = '0;
    logic [NP*2-1:0]   port_resp = '0;

    scr1_imem_router_mp #(
        .NPORTS    (NP),
        .OUTST_MAX (OM),
        .ADDR_MASK ({NP{32'hFFFF_0000}}),
        .ADDR_PATT ({32'h0002_0000, 32'h0001_0000, 32'h0000_0000})
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_cmd     (imem_cmd),
        .imem_addr    (imem_addr),
        .imem_req_ack (imem_req_ack),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .port_req     (port_req),
        .port_cmd     (port_cmd),
        .port_addr    (port_addr),
        .port_req_ack (port_req_ack),
        .port_rdata   (port_rdata),
        .port_resp    (port_resp)
    );

    // Reference state: targets of in-flight fetches (NP = local error), and per-port pending addresses
    int          inflight[$];
    logic [31:0] pq[NP][$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Window index is the upper address half; anything outside 0..NP-1 matches no window
    function automatic int decode(input logic [31:0] a);
        int w;
        w = int'(a[31:16]);
        if (w < NP) return w;
`ifdef SCR1_IMEM_ROUTER_DECERR_EN
        return NP;
`else
        return NP - 1;
`endif
    endfunction

    function automatic logic [31:0] port_data(input int p, input logic [31:0] a);
        return a ^ (32'h1357_0000 + 32'(p) * 32'h0101_0101);
    endfunction

    // One clock of stimulus, prediction, comparison and reference update
    task automatic step(input logic req, input logic [31:0] addr, input logic cmd,
                        input logic [NP-1:0] acks, input int resp_pct);
        logic [1:0]  r [NP];
        logic [31:0] d [NP];
        int head, sel, left;
        logic pop, can, exp_ack;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        logic [NP-1:0] exp_preq, exp_pcmd;
        @(negedge clk);
        imem_req = req; imem_addr = addr; imem_cmd = cmd; port_req_ack = acks;
        for (int p = 0; p < NP; p++) begin
            d[p] = $urandom;
            r[p] = NOTRDY;
            if (pq[p].size() > 0 && int'($urandom_range(99)) < resp_pct) begin
                r[p] = ($urandom_range(7) == 0) ? RDY_ER : RDY_OK;
                d[p] = port_data(p, pq[p][0]);
            end
            port_resp[p*2 +: 2]   = r[p];
            port_rdata[p*32 +: 32] = d[p];
        end
        #1;
        head = (inflight.size() > 0) ? inflight[0] : -1;
        pop = 1'b0; exp_resp = NOTRDY; exp_data = '0;
        if (head == NP) begin
            pop = 1'b1; exp_resp = RDY_ER;
        end else if (head >= 0) begin
            exp_resp = r[head]; exp_data = d[head];
            pop = (r[head] != NOTRDY);
        end
        left = inflight.size() - int'(pop);
        sel  = decode(addr);
        can  = req && (left < OM) && (left == 0 || sel == head) && (sel < NP || left == 0);
        exp_ack  = can && ((sel == NP) || acks[sel]);
        exp_preq = '0; exp_pcmd = '0;
        if (sel < NP) begin
            exp_preq[sel] = can;
            exp_pcmd[sel] = cmd;
        end
        chk("imem_req_ack", 64'(imem_req_ack), 64'(exp_ack));
        chk("port_req", 64'(port_req), 64'(exp_preq));
        chk("port_cmd", 64'(port_cmd), 64'(exp_pcmd));
        chk("imem_resp", 64'(imem_resp), 64'(exp_resp));
        chk("imem_rdata", 64'(imem_rdata), 64'(exp_data));
        for (int p = 0; p < NP; p++)
            chk("port_addr", 64'(port_addr[p*32 +: 32]), (p == sel) ? 64'(addr) : 64'h0);
        @(posedge clk);
        if (pop) begin
            $display("resp from %0d: resp=%0d data=%h", head, exp_resp, exp_data);
            void'(inflight.pop_front());
            if (head < NP) void'(pq[head].pop_front());
        end
        if (exp_ack) begin
            $display("fetch %h -> port %0d", addr, sel);
            inflight.push_back(sel);
            if (sel < NP) pq[sel].push_back(addr);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ack"},   64'(imem_req_ack), 64'h0);
        chk({tag, "_preq"},  64'(port_req), 64'h0);
        chk({tag, "_resp"},  64'(imem_resp), 64'(NOTRDY));
        chk({tag, "_rdata"}, 64'(imem_rdata), 64'h0);
    endtask

    initial begin
        int tgt;
        logic [31:0] a;
        // Power-on reset with a pending request and responding ports: nothing may leak out
        imem_req = 1'b1; port_req_ack = '1; port_resp = {NP{RDY_OK}}; port_rdata = {NP{32'hDEAD_BEEF}};
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1; imem_req = 1'b0; port_resp = '0;

        // Single fetch to window 1, answered on the next cycle
        step(1'b1, 32'h0001_0000, 1'b0, '1, 0);
        step(1'b0, 32'h0, 1'b0, '1, 100);
        // Three back-to-back fetches to port 0 with delayed responses; the third waits for the first pop
        step(1'b1, 32'h0000_0010, 1'b0, '1, 0);
        step(1'b1, 32'h0000_0014, 1'b0, '1, 0);
        repeat (2) step(1'b1, 32'h0000_0018, 1'b0, '1, 0);
        repeat (3) step(1'b1, 32'h0000_0018, 1'b0, '1, 100);
        // Port switch to port 2 while port 0 still holds fetches
        repeat (4) step(1'b1, 32'h0002_0020, 1'b1, '1, 0);
        repeat (4) step(1'b1, 32'h0002_0020, 1'b1, '1, 100);
        repeat (3) step(1'b0, 32'h0, 1'b0, '1, 100);
        // Unmatched address
        step(1'b1, 32'hFFFF_0000, 1'b0, '1, 100);
        repeat (3) step(1'b0, 32'h0, 1'b0, '1, 100);

        // Reset in the middle of two in-flight fetches on port 1
        step(1'b1, 32'h0001_0100, 1'b0, '1, 0);
        step(1'b1, 32'h0001_0104, 1'b0, '1, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        imem_req = 1'b1; imem_addr = 32'h0001_0108; port_req_ack = '1;
        port_resp = {NP{RDY_OK}};
        #1 check_idle_outputs("mid_reset");
        inflight.delete();
        for (int p = 0; p < NP; p++) pq[p].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; imem_req = 1'b0;
        // Late responses from port 1 after release must be ignored
        #1 check_idle_outputs("stray");
        port_resp = '0;

        // Randomised traffic with sticky targets so streaks and switches both occur
        tgt = 0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(4) == 0) tgt = int'($urandom_range(NP));
            a = (tgt == NP) ? {16'hFFFF, 16'($urandom)} : {16'(tgt), 16'($urandom)};
            step($urandom_range(9) < 8, a, 1'($urandom), NP'($urandom | $urandom), 40);
        end
        repeat (20) step(1'b0, 32'h0, 1'b0, '1, 100);
        chk("drained", 64'(inflight.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
